// File: rtl/ct_f_spsram_rmw_ctrl.sv
// Request-side controller for a 16384x128 single-port SRAM wrapper.
// Ports: req_* single-beat read / byte-masked write request (valid/ready);
//        rsp_* one-entry read response buffer (valid/ready);
//        sram_* registered A/CEN/GWEN/WEN/D pins, sram_q read data.
// Partial writes become read-modify-write because the SRAM only does
// full-line writes.
module ct_f_spsram_rmw_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISS,
        RD_DATA,
        WR_ISS
    } state_t;

    state_t                state_q, state_d;
    logic                  cen_q, cen_d;
    logic                  gwen_q, gwen_d;
    logic [DATA_WIDTH-1:0] wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   bmask_q, bmask_d;
    logic                  rmw_q, rmw_d;

    logic                  accept;
    logic                  is_full;
    logic                  is_nop;
    logic [DATA_WIDTH-1:0] merged;

    assign req_rdy = cpurst_b && (state_q == IDLE) && !rsp_vld_q;
    assign accept  = req_vld && req_rdy;
    assign is_full = &req_bmask;
    assign is_nop  = ~|req_bmask;

    // Byte merge of the buffered write data over the line just read.
    always_comb begin
        merged = sram_q;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (bmask_q[i]) begin
                merged[i*8 +: 8] = wdata_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cen_d      = cen_q;
        gwen_d     = gwen_q;
        wen_d      = wen_q;
        a_d        = a_q;
        d_d        = d_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_data_d = rsp_data_q;
        wdata_d    = wdata_q;
        bmask_d    = bmask_q;
        rmw_d      = rmw_q;

        if (rsp_vld_q && rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_wr || (!is_full && !is_nop)) begin
                        cen_d   = 1'b0;
                        gwen_d  = 1'b1;
                        wen_d   = '1;
                        a_d     = req_addr;
                        wdata_d = req_wdata;
                        bmask_d = req_bmask;
                        rmw_d   = req_wr;
                        state_d = RD_ISS;
                    end else if (is_full) begin
                        cen_d   = 1'b0;
                        gwen_d  = 1'b0;
                        wen_d   = '0;
                        a_d     = req_addr;
                        d_d     = req_wdata;
                        state_d = WR_ISS;
                    end
                end
            end
            RD_ISS: begin
                cen_d   = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rmw_q) begin
                    d_d     = merged;
                    cen_d   = 1'b0;
                    gwen_d  = 1'b0;
                    wen_d   = '0;
                    state_d = WR_ISS;
                end else begin
                    rsp_data_d = sram_q;
                    rsp_vld_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            WR_ISS: begin
                cen_d   = 1'b1;
                gwen_d  = 1'b1;
                wen_d   = '1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_q    <= IDLE;
            cen_q      <= 1'b1;
            gwen_q     <= 1'b1;
            wen_q      <= '1;
            a_q        <= '0;
            d_q        <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            rmw_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cen_q      <= cen_d;
            gwen_q     <= gwen_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            d_q        <= d_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_data_q <= rsp_data_d;
            wdata_q    <= wdata_d;
            bmask_q    <= bmask_d;
            rmw_q      <= rmw_d;
        end
    end

    assign sram_a    = a_q;
    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_d    = d_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ct_f_spsram_rmw_ctrl.sv
// Bench for ct_f_spsram_rmw_ctrl: SRAM model, transaction-level
// reference model with per-cycle compare, and directed scenarios.
module tb_ct_f_spsram_rmw_ctrl;

    logic          clk = 1'b0;
    logic          cpurst_b = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [13:0]   req_addr = '0;
    logic [127:0]  req_wdata = '0;
    logic [15:0]   req_bmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic [127:0]  rsp_data;
    logic [13:0]   sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [127:0]  sram_wen;
    logic [127:0]  sram_d;
    logic [127:0]  sram_q = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ct_f_spsram_rmw_ctrl dut (
        .forever_cpuclk(clk),
        .cpurst_b(cpurst_b),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_bmask(req_bmask),
        .rsp_vld(rsp_vld),
        .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data),
        .sram_a(sram_a),
        .sram_cen(sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen(sram_wen),
        .sram_d(sram_d),
        .sram_q(sram_q)
    );

    // SRAM: one-cycle read latency, write honours WEN[127] only.
    logic [127:0] mem [16384];
    always @(posedge clk) begin
        if (sram_cen == 1'b0) begin
            if (sram_gwen == 1'b0 && sram_wen[127] == 1'b0)
                mem[sram_a] <= sram_d;
            else
                sram_q <= mem[sram_a];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Reference model: tracks request kind, remaining busy cycles,
    // the expected SRAM command each cycle and a shadow memory.
    localparam int K_RD = 0;
    localparam int K_FW = 1;
    localparam int K_RMW = 2;
    logic [127:0] ref_mem [16384];
    int           m_busy = 0;
    int           m_kind = 0;
    logic [13:0]  m_addr = '0;
    logic [127:0] m_wdata = '0;
    logic [15:0]  m_mask = '0;
    logic [127:0] m_wd = '0;
    logic         m_cen_lo = 1'b0;
    logic         m_we = 1'b0;
    logic         m_rsp_v = 1'b0;
    logic [127:0] m_rsp_d = '0;

    always @(posedge clk) begin : mdl
        logic acc;
        int b;
        logic [127:0] line;
        m_cen_lo <= 1'b0;
        m_we <= 1'b0;
        if (!cpurst_b) begin
            m_busy <= 0;
            m_rsp_v <= 1'b0;
            m_rsp_d <= '0;
        end else begin
            acc = req_vld && m_busy == 0 && !m_rsp_v;
            if (m_rsp_v && rsp_rdy) m_rsp_v <= 1'b0;
            if (m_busy != 0) begin
                b = m_busy - 1;
                m_busy <= b;
                if (b == 1 && m_kind == K_RMW) begin
                    line = ref_mem[m_addr];
                    for (int i = 0; i < 16; i++)
                        if (m_mask[i]) line[i*8 +: 8] = m_wdata[i*8 +: 8];
                    m_wd <= line;
                    m_cen_lo <= 1'b1;
                    m_we <= 1'b1;
                end
                if (b == 0) begin
                    if (m_kind == K_RD) begin
                        m_rsp_v <= 1'b1;
                        m_rsp_d <= ref_mem[m_addr];
                    end else begin
                        ref_mem[m_addr] <= m_wd;
                    end
                end
            end
            if (acc && !(req_wr && req_bmask == 16'h0)) begin
                m_addr <= req_addr;
                m_wdata <= req_wdata;
                m_mask <= req_bmask;
                m_cen_lo <= 1'b1;
                if (!req_wr) begin
                    m_kind <= K_RD;
                    m_busy <= 2;
                end else if (req_bmask == 16'hFFFF) begin
                    m_kind <= K_FW;
                    m_busy <= 1;
                    m_we <= 1'b1;
                    m_wd <= req_wdata;
                end else begin
                    m_kind <= K_RMW;
                    m_busy <= 3;
                end
            end
        end
    end

    int   gwen_cnt = 0;
    int   cen_cnt = 0;
    logic prev_lo = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_rdy", req_rdy, cpurst_b && m_busy == 0 && !m_rsp_v);
            chk("rsp_vld", rsp_vld, m_rsp_v);
            chk("rsp_data", rsp_data, m_rsp_d);
            chk("sram_cen", sram_cen, !m_cen_lo);
            chk("sram_gwen", sram_gwen, !m_we);
            chk("sram_wen", sram_wen, {128{!m_we}});
            if (m_cen_lo) chk("sram_a", sram_a, m_addr);
            if (m_we) chk("sram_d", sram_d, m_wd);
            chk("cen_b2b", prev_lo && !sram_cen, 1'b0);
            prev_lo <= !sram_cen;
            if (!sram_gwen) gwen_cnt <= gwen_cnt + 1;
            if (!sram_cen) cen_cnt <= cen_cnt + 1;
        end
    end

    // Called just after a posedge; returns 2 time units after the
    // accepting edge with req_vld dropped and acc_cyc set.
    task automatic do_req(input logic wr, input logic [13:0] addr,
                          input logic [127:0] data, input logic [15:0] mask);
        bit got;
        got = 1'b0;
        req_vld = 1'b1;
        req_wr = wr;
        req_addr = addr;
        req_wdata = data;
        req_bmask = mask;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (req_rdy) begin
                @(posedge clk);
                got = 1'b1;
                break;
            end
        end
        if (!got) @(posedge clk);
        #2;
        acc_cyc = cyc;
        req_vld = 1'b0;
        chk("accept_timeout", got, 1'b1);
    endtask

    task automatic do_read(input logic [13:0] addr, output logic [127:0] data);
        do_req(1'b0, addr, '0, '0);
        @(posedge clk);
        #1 chk("rd_lat_e1", rsp_vld, 1'b0);
        @(posedge clk);
        #1 chk("rd_lat_e2", rsp_vld, 1'b1);
        data = rsp_data;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] PAT = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

    initial begin
        logic [127:0] rd;
        logic [31:0] w;
        int c0;
        int a_prev;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cen", sram_cen, 1'b1);
        chk("rst_gwen", sram_gwen, 1'b1);
        chk("rst_wen", sram_wen, {128{1'b1}});
        chk("rst_a", sram_a, 14'h0);
        chk("rst_d", sram_d, 128'h0);
        chk("rst_rsp_vld", rsp_vld, 1'b0);
        chk("rst_rsp_data", rsp_data, 128'h0);
        chk("rst_req_rdy", req_rdy, 1'b0);
        chk_en = 1'b1;
        #1 cpurst_b = 1'b1;

        c0 = gwen_cnt;
        do_req(1'b1, 14'h0005, D1, 16'hFFFF);
        do_read(14'h0005, rd);
        chk("t1_readback", rd, D1);
        repeat (3) @(posedge clk);
        #2 chk("t1_gwen_cycles", 32'(gwen_cnt - c0), 32'd1);

        do_req(1'b1, 14'h3FFF, {16{8'hAA}}, 16'hFFFF);
        do_req(1'b1, 14'h3FFF, {16{8'h55}}, 16'h0001);
        @(negedge clk);
        chk("t2_e1_cen", sram_cen, 1'b0);
        chk("t2_e1_gwen", sram_gwen, 1'b1);
        @(negedge clk);
        chk("t2_e2_cen", sram_cen, 1'b1);
        @(negedge clk);
        chk("t2_e3_cen", sram_cen, 1'b0);
        chk("t2_e3_gwen", sram_gwen, 1'b0);
        @(posedge clk);
        #2;
        do_read(14'h3FFF, rd);
        chk("t2_readback", rd, {{15{8'hAA}}, 8'h55});

        repeat (2) @(posedge clk);
        #2 c0 = cen_cnt;
        do_req(1'b1, 14'h0020, PAT, 16'h0000);
        a_prev = acc_cyc;
        do_req(1'b1, 14'h0021, PAT, 16'h0000);
        chk("t3_nop_rate1", 32'(acc_cyc - a_prev), 32'd1);
        a_prev = acc_cyc;
        do_req(1'b1, 14'h0022, PAT, 16'h0000);
        chk("t3_nop_rate2", 32'(acc_cyc - a_prev), 32'd1);
        @(negedge clk);
        chk("t3_rdy", req_rdy, 1'b1);
        chk("t3_no_cen", 32'(cen_cnt - c0), 32'd0);
        @(posedge clk);
        #2;

        rsp_rdy = 1'b0;
        do_read(14'h0005, rd);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_vld", rsp_vld, 1'b1);
            chk("t4_hold_data", rsp_data, D1);
            chk("t4_hold_rdy", req_rdy, 1'b0);
        end
        @(posedge clk);
        #2;
        c0 = cyc;
        rsp_rdy = 1'b1;
        do_req(1'b1, 14'h0030, PAT, 16'h0000);
        chk("t4_resume", 32'(acc_cyc - c0), 32'd2);

        do_req(1'b1, 14'h0100, PAT, 16'hFFFF);
        do_req(1'b1, 14'h0100, {16{8'hEE}}, 16'h00F0);
        @(posedge clk);
        #2 cpurst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rst_cen", sram_cen, 1'b1);
        chk("t5_rst_vld", rsp_vld, 1'b0);
        #1 cpurst_b = 1'b1;
        do_read(14'h0100, rd);
        chk("t5_unchanged", rd, PAT);

        for (int i = 0; i < 16; i++) begin
            w = 32'hDEADBEEF ^ (32'(i) * 32'h01010101);
            do_req(1'b1, 14'(i), {4{w}}, 16'hFFFF);
            if (i > 0) chk("t6_rate", 32'(acc_cyc - a_prev), 32'd2);
            a_prev = acc_cyc;
        end
        for (int i = 0; i < 16; i++) begin
            w = 32'hDEADBEEF ^ (32'(i) * 32'h01010101);
            do_read(14'(i), rd);
            chk("t6_readback", rd, {4{w}});
        end

        repeat (4) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
